snake_head_stepper: RTL and testbench

Consumer of the 3-bit direction code produced by the keypad direction encoder. Latches each legal direction request, rejects 180° reversals against the committed heading, and moves the snake head one grid cell per game tick with toroidal wrap-around. Sits between the direction encoder and the snake body/collision logic, clocked on VGA_CLK.

---
 rtl/snake_head_stepper.sv | 137 +++++++++++++
 tb/tb_snake_head_stepper.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/snake_head_stepper.sv
`default_nettype none
// snake_head_stepper: latches legal direction requests (no 180-degree reversals) and
// steps the snake head one grid cell per game tick with toroidal wrap-around.
module snake_head_stepper #(
   parameter int GRID_W   = 40,
   parameter int GRID_H   = 30,
   parameter int TICK_DIV = 2500000,
   parameter int START_X  = 20,
   parameter int START_Y  = 15
) (
   input  logic       VGA_CLK,
   input  logic       reset,
   input  logic [2:0] direction,
   input  logic       enable,
   output logic [5:0] head_x,
   output logic [4:0] head_y,
   output logic [2:0] heading,
   output logic       step,
   output logic       wrapped
);

   localparam int               CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [5:0]       X_MAX     = 6'(GRID_W - 1);
   localparam logic [4:0]       Y_MAX     = 5'(GRID_H - 1);
   localparam logic [5:0]       X_START   = 6'(START_X);
   localparam logic [4:0]       Y_START   = 5'(START_Y);

   localparam logic [2:0] DIR_NONE  = 3'd0;
   localparam logic [2:0] DIR_UP    = 3'd1;
   localparam logic [2:0] DIR_DOWN  = 3'd2;
   localparam logic [2:0] DIR_LEFT  = 3'd3;
   localparam logic [2:0] DIR_RIGHT = 3'd4;

   logic [2:0]       pending;
   logic [2:0]       opposite;
   logic [2:0]       eff;
   logic             legal;
   logic             tick;
   logic [CNT_W-1:0] tick_cnt;
   logic [5:0]       next_x;
   logic [4:0]       next_y;
   logic             next_wrap;

   // Legality is judged against the committed heading, never against pending,
   // so two quick presses between ticks cannot reverse the snake.
   always_comb begin
      opposite = DIR_NONE;
      case (heading)
         DIR_UP:    opposite = DIR_DOWN;
         DIR_DOWN:  opposite = DIR_UP;
         DIR_LEFT:  opposite = DIR_RIGHT;
         DIR_RIGHT: opposite = DIR_LEFT;
         default:   opposite = DIR_NONE;
      endcase
   end

   assign legal = (direction >= DIR_UP) && (direction <= DIR_RIGHT) && (direction != opposite);
   assign eff   = legal ? direction : pending;
   assign tick  = enable && (tick_cnt == TICK_LAST);

   always_comb begin
      next_x    = head_x;
      next_y    = head_y;
      next_wrap = 1'b0;
      case (eff)
         DIR_UP: begin
            if (head_y == 5'd0) begin
               next_y    = Y_MAX;
               next_wrap = 1'b1;
            end else begin
               next_y = head_y - 5'd1;
            end
         end
         DIR_DOWN: begin
            if (head_y == Y_MAX) begin
               next_y    = 5'd0;
               next_wrap = 1'b1;
            end else begin
               next_y = head_y + 5'd1;
            end
         end
         DIR_LEFT: begin
            if (head_x == 6'd0) begin
               next_x    = X_MAX;
               next_wrap = 1'b1;
            end else begin
               next_x = head_x - 6'd1;
            end
         end
         DIR_RIGHT: begin
            if (head_x == X_MAX) begin
               next_x    = 6'd0;
               next_wrap = 1'b1;
            end else begin
               next_x = head_x + 6'd1;
            end
         end
         default: begin
            next_x    = head_x;
            next_y    = head_y;
            next_wrap = 1'b0;
         end
      endcase
   end

   always_ff @(posedge VGA_CLK) begin
      if (!reset) begin
         head_x   <= X_START;
         head_y   <= Y_START;
         heading  <= DIR_NONE;
         pending  <= DIR_NONE;
         tick_cnt <= '0;
         step     <= 1'b0;
         wrapped  <= 1'b0;
      end else begin
         pending <= eff;
         step    <= 1'b0;
         wrapped <= 1'b0;
         if (tick) begin
            tick_cnt <= '0;
            if (eff != DIR_NONE) begin
               heading <= eff;
               head_x  <= next_x;
               head_y  <= next_y;
               step    <= 1'b1;
               wrapped <= next_wrap;
            end
         end else if (enable) begin
            tick_cnt <= tick_cnt + CNT_ONE;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_snake_head_stepper.sv
`default_nettype none
// Directed bench for snake_head_stepper on an 8x8 grid, TICK_DIV=4, start (4,4).
module tb_snake_head_stepper;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic [2:0] dir;
      logic [5:0] x;
      logic [4:0] y;
      logic [2:0] h;
      logic       s;
      logic       w;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [2:0] direction;
   logic       enable;
   logic [5:0] head_x;
   logic [4:0] head_y;
   logic [2:0] heading;
   logic       step;
   logic       wrapped;

   int checks   = 0;
   int failures = 0;

   vec_t vecs[128];
   int   nv = 0;
   logic [5:0] ex;
   logic [4:0] ey;
   logic [2:0] eh;

   snake_head_stepper #(
      .GRID_W(8), .GRID_H(8), .TICK_DIV(4), .START_X(4), .START_Y(4)
   ) dut (
      .VGA_CLK(clk),
      .reset(reset),
      .direction(direction),
      .enable(enable),
      .head_x(head_x),
      .head_y(head_y),
      .heading(heading),
      .step(step),
      .wrapped(wrapped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic push(input logic r, input logic e, input logic [2:0] d,
                       input logic [5:0] x, input logic [4:0] y, input logic [2:0] h,
                       input logic s, input logic w);
      vecs[nv] = '{rst_n: r, en: e, dir: d, x: x, y: y, h: h, s: s, w: w};
      nv++;
   endtask

   // One full tick interval: requests on the first two cycles, step on the fourth.
   task automatic interval(input logic [2:0] d0, input logic [2:0] d1,
                           input logic [5:0] nx, input logic [4:0] ny,
                           input logic [2:0] nh, input logic nw);
      push(1, 1, d0, ex, ey, eh, 0, 0);
      push(1, 1, d1, ex, ey, eh, 0, 0);
      push(1, 1, 0, ex, ey, eh, 0, 0);
      push(1, 1, 0, nx, ny, nh, 1, nw);
      ex = nx;
      ey = ny;
      eh = nh;
   endtask

   task automatic cyc(input logic r, input logic e, input logic [2:0] d);
      reset     = r;
      enable    = e;
      direction = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [5:0] x, input logic [4:0] y,
                        input logic [2:0] h, input logic s, input logic w);
      checks++;
      if (head_x !== x || head_y !== y || heading !== h || step !== s || wrapped !== w) begin
         failures++;
         $display("FAIL %s: got x=%0d y=%0d heading=%0d step=%0d wrapped=%0d, want x=%0d y=%0d heading=%0d step=%0d wrapped=%0d",
                  name, head_x, head_y, heading, step, wrapped, x, y, h, s, w);
      end
   endtask

   initial begin
      reset     = 1'b0;
      enable    = 1'b0;
      direction = 3'd0;
      ex = 6'd4;
      ey = 5'd4;
      eh = 3'd0;

      for (int i = 0; i < 3; i++) push(0, 1, 0, 4, 4, 0, 0, 0);
      for (int i = 0; i < 12; i++) push(1, 1, 0, 4, 4, 0, 0, 0);
      // Right along row 4, wrapping at the right edge.
      interval(4, 0, 5, 4, 4, 0);
      interval(0, 0, 6, 4, 4, 0);
      interval(0, 0, 7, 4, 4, 0);
      interval(0, 0, 0, 4, 4, 1);
      // Reversal rejection against heading, then a legal turn.
      interval(0, 3, 1, 4, 4, 0);
      interval(1, 3, 1, 3, 1, 0);
      interval(0, 0, 1, 2, 1, 0);
      interval(3, 0, 0, 2, 3, 0);
      // Walk to (2,0) heading up, then wrap over the top edge.
      interval(1, 0, 0, 1, 1, 0);
      interval(4, 0, 1, 1, 4, 0);
      interval(0, 0, 2, 1, 4, 0);
      interval(1, 0, 2, 0, 1, 0);
      interval(0, 0, 2, 7, 1, 1);

      for (int i = 0; i < nv; i++) begin
         cyc(vecs[i].rst_n, vecs[i].en, vecs[i].dir);
         check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].h, vecs[i].s, vecs[i].w);
      end

      // Pause at tick_cnt=2; a request while paused still updates pending.
      cyc(1, 1, 0); check("pause_pre", 2, 7, 1, 0, 0);
      cyc(1, 1, 0); check("pause_pre", 2, 7, 1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, (i == 5) ? 3'd3 : 3'd0);
         check("pause_hold", 2, 7, 1, 0, 0);
      end
      cyc(1, 1, 0); check("pause_resume", 2, 7, 1, 0, 0);
      cyc(1, 1, 0); check("pause_step", 1, 7, 3, 1, 0);

      // Request in the tick cycle commits on that tick.
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0); check("zl_wait", 1, 7, 3, 0, 0);
      end
      cyc(1, 1, 1); check("zero_latency", 1, 6, 1, 1, 0);

      // Reversal in the tick cycle falls back to pending.
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0); check("rev_wait", 1, 6, 1, 0, 0);
      end
      cyc(1, 1, 2); check("tick_reversal", 1, 5, 1, 1, 0);

      // Reset landing on the tick cycle drops the step.
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0); check("rst_wait", 1, 5, 1, 0, 0);
      end
      cyc(0, 1, 0); check("reset_in_tick", 4, 4, 0, 0, 0);

      // Invalid codes leave pending and heading untouched.
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 6); check("invalid_idle", 4, 4, 0, 0, 0);
      end
      cyc(1, 1, 4); check("inv_req", 4, 4, 0, 0, 0);
      cyc(1, 1, 0); check("inv_req", 4, 4, 0, 0, 0);
      cyc(1, 1, 0); check("inv_req", 4, 4, 0, 0, 0);
      cyc(1, 1, 6); check("invalid_at_tick", 5, 4, 4, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 7); check("invalid7_wait", 5, 4, 4, 0, 0);
      end
      cyc(1, 1, 7); check("invalid7_step", 6, 4, 4, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
